// File: rtl/avalon_st_pkg.sv
// avalon_st_pkg
//   Shared definitions for the byte-wide Avalon-ST operand/result link.
//   Holds the default operand and beat widths, the beat counts and counter
//   width derived from those defaults, and the link FSM state type. The
//   initiator wrapper uses the same state type.
package avalon_st_pkg;

  localparam int SZ_DEFAULT  = 32;
  localparam int DSZ_DEFAULT = 8;

  localparam int NIN   = 2 * SZ_DEFAULT / DSZ_DEFAULT;
  localparam int NOUT  = 2 * SZ_DEFAULT / DSZ_DEFAULT;
  localparam int CNT_W = $clog2(NIN);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RECV = 3'd1,
    DROP = 3'd2,
    CALC = 3'd3,
    SEND = 3'd4
  } avst_state_t;

endpackage

// File: rtl/avalon_st_tx_serializer.sv
// avalon_st_tx_serializer
//   Loads a 2*SZ-bit word and sends it as 2*SZ/DSZ beats, least-significant
//   beat first. sop is flagged on the first beat and eop on the last. While
//   ready_in is low, the presented beat and its flags hold stable.
// Ports:
//   clk       clock, rising edge
//   _rst      synchronous reset, active-high
//   load      one-cycle pulse: capture word and start a packet
//   word      2*SZ-bit value to send
//   ready_in  downstream accepts the presented beat
//   data      current beat (DSZ bits)
//   valid     a beat is being presented
//   sop, eop  first / last beat of the packet
//   done      last beat is accepted on this edge
module avalon_st_tx_serializer
  import avalon_st_pkg::*;
#(
  parameter int SZ  = SZ_DEFAULT,
  parameter int DSZ = DSZ_DEFAULT
) (
  input  logic              clk,
  input  logic              _rst,
  input  logic              load,
  input  logic [2*SZ-1:0]   word,
  input  logic              ready_in,
  output logic [DSZ-1:0]    data,
  output logic              valid,
  output logic              sop,
  output logic              eop,
  output logic              done
);

  localparam int OUT_BEATS = 2 * SZ / DSZ;
  localparam int BEAT_W    = $clog2(OUT_BEATS);
  localparam logic [BEAT_W-1:0] LAST = BEAT_W'(OUT_BEATS - 1);

  logic [2*SZ-1:0]   shreg;
  logic [BEAT_W-1:0] beat;
  logic              valid_q;

  always_ff @(posedge clk) begin
    if (_rst) begin
      shreg   <= '0;
      beat    <= '0;
      valid_q <= 1'b0;
    end else if (load) begin
      shreg   <= word;
      beat    <= '0;
      valid_q <= 1'b1;
    end else if (valid_q && ready_in) begin
      shreg <= shreg >> DSZ;
      if (beat == LAST) begin
        beat    <= '0;
        valid_q <= 1'b0;
      end else begin
        beat <= beat + BEAT_W'(1);
      end
    end
  end

  assign data  = shreg[DSZ-1:0];
  assign valid = valid_q;
  assign sop   = valid_q && (beat == '0);
  assign eop   = valid_q && (beat == LAST);
  assign done  = valid_q && ready_in && (beat == LAST);

endmodule

// File: rtl/avalon_st_mul_responder.sv
// avalon_st_mul_responder
//   Responder end of the byte-wide Avalon-ST operand/result link. It receives
//   one packet of A then B (each LSB first), computes the full-width unsigned
//   product A*B and sends it back as one result packet, LSB first.
//   Single clock domain; ready latency 0 on both directions.
// Ports:
//   clk, _rst             clock (rising edge), synchronous active-high reset
//   data_in, valid_in     operand beat and its valid
//   startofpacket_in      first operand beat
//   endofpacket_in        last operand beat
//   ready_out             responder accepts an operand beat
//   data_out, valid_out   result beat and its valid
//   startofpacket_out     first result beat
//   endofpacket_out       last result beat
//   ready_in              initiator accepts the result beat
//   err_cnt               (only with AVST_MUL_ERR_CNT_EN) saturating count of
//                         short/long operand packets
//
// state | meaning
// IDLE  | waiting for a sop beat; non-sop beats are discarded
// RECV  | collecting operand bytes into op_reg
// DROP  | over-long packet; discarding beats until eop
// CALC  | one cycle: product registered, ready_out low
// SEND  | result packet in flight through the serializer
module avalon_st_mul_responder
  import avalon_st_pkg::*;
#(
  parameter int SZ  = SZ_DEFAULT,
  parameter int DSZ = DSZ_DEFAULT
) (
  input  logic           clk,
  input  logic           _rst,
  input  logic [DSZ-1:0] data_in,
  input  logic           valid_in,
  input  logic           startofpacket_in,
  input  logic           endofpacket_in,
  output logic           ready_out,
  output logic [DSZ-1:0] data_out,
  output logic           valid_out,
  output logic           startofpacket_out,
  output logic           endofpacket_out,
  input  logic           ready_in
`ifdef AVST_MUL_ERR_CNT_EN
  ,
  output logic [7:0]     err_cnt
`endif
);

  localparam int IN_BEATS = 2 * SZ / DSZ;
  localparam int BEAT_W   = $clog2(IN_BEATS);
  localparam logic [BEAT_W-1:0] LAST = BEAT_W'(IN_BEATS - 1);

  avst_state_t       state, state_n;
  logic [BEAT_W-1:0] cnt, cnt_n;
  logic [BEAT_W-1:0] store_idx;
  logic              store_en;
  logic              err_evt;
  logic              accept;
  logic              tx_done;
  logic              load_q;
  logic [2*SZ-1:0]   op_reg;
  logic [2*SZ-1:0]   prod_reg;
  logic [2*SZ-1:0]   op_a_ext;
  logic [2*SZ-1:0]   op_b_ext;

  assign ready_out = !_rst && (state inside {IDLE, RECV, DROP});
  assign accept    = valid_in && ready_out;

  always_ff @(posedge clk) begin
    if (_rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    store_en  = 1'b0;
    store_idx = cnt;
    err_evt   = 1'b0;
    case (state)
      IDLE: begin
        if (accept && startofpacket_in) begin
          if (endofpacket_in) begin
            err_evt = 1'b1;
          end else begin
            store_en  = 1'b1;
            store_idx = '0;
            cnt_n     = BEAT_W'(1);
            state_n   = RECV;
          end
        end
      end
      RECV: begin
        if (accept) begin
          if (startofpacket_in) begin
            // A fresh sop restarts collection; sop+eop together is a
            // one-beat packet and therefore short.
            if (endofpacket_in) begin
              err_evt = 1'b1;
              cnt_n   = '0;
              state_n = IDLE;
            end else begin
              store_en  = 1'b1;
              store_idx = '0;
              cnt_n     = BEAT_W'(1);
            end
          end else if (endofpacket_in) begin
            cnt_n = '0;
            if (cnt == LAST) begin
              store_en = 1'b1;
              state_n  = CALC;
            end else begin
              err_evt = 1'b1;
              state_n = IDLE;
            end
          end else if (cnt == LAST) begin
            err_evt = 1'b1;
            cnt_n   = '0;
            state_n = DROP;
          end else begin
            store_en = 1'b1;
            cnt_n    = cnt + BEAT_W'(1);
          end
        end
      end
      DROP: begin
        if (accept && endofpacket_in) state_n = IDLE;
      end
      CALC: state_n = SEND;
      SEND: begin
        if (tx_done) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (_rst) begin
      op_reg <= '0;
    end else if (store_en) begin
      for (int i = 0; i < IN_BEATS; i++) begin
        if (store_idx == BEAT_W'(i)) op_reg[i*DSZ +: DSZ] <= data_in;
      end
    end
  end

  assign op_a_ext = {{SZ{1'b0}}, op_reg[SZ-1:0]};
  assign op_b_ext = {{SZ{1'b0}}, op_reg[2*SZ-1:SZ]};

  // The multiplier output is registered in CALC and loaded into the
  // serializer one edge later, so the wide multiply gets a full cycle.
  always_ff @(posedge clk) begin
    if (_rst) begin
      prod_reg <= '0;
      load_q   <= 1'b0;
    end else begin
      load_q <= (state == CALC);
      if (state == CALC) prod_reg <= op_a_ext * op_b_ext;
    end
  end

  avalon_st_tx_serializer #(
    .SZ  (SZ),
    .DSZ (DSZ)
  ) u_tx (
    .clk      (clk),
    ._rst     (_rst),
    .load     (load_q),
    .word     (prod_reg),
    .ready_in (ready_in),
    .data     (data_out),
    .valid    (valid_out),
    .sop      (startofpacket_out),
    .eop      (endofpacket_out),
    .done     (tx_done)
  );

`ifdef AVST_MUL_ERR_CNT_EN
  always_ff @(posedge clk) begin
    if (_rst) begin
      err_cnt <= '0;
    end else if (err_evt && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`else
  logic unused_err_evt;
  assign unused_err_evt = err_evt;
`endif

endmodule

// File: tb/tb_avalon_st_mul_responder.sv
module tb_avalon_st_mul_responder;

  logic       clk;
  logic       _rst;
  logic [7:0] data_in;
  logic       valid_in;
  logic       sop_in;
  logic       eop_in;
  logic       ready_out;
  logic [7:0] data_out;
  logic       valid_out;
  logic       sop_out;
  logic       eop_out;
  logic       ready_in;
`ifdef AVST_MUL_ERR_CNT_EN
  logic [7:0] err_cnt;
`endif

  avalon_st_mul_responder dut (
    .clk               (clk),
    ._rst              (_rst),
    .data_in           (data_in),
    .valid_in          (valid_in),
    .startofpacket_in  (sop_in),
    .endofpacket_in    (eop_in),
    .ready_out         (ready_out),
    .data_out          (data_out),
    .valid_out         (valid_out),
    .startofpacket_out (sop_out),
    .endofpacket_out   (eop_out),
    .ready_in          (ready_in)
`ifdef AVST_MUL_ERR_CNT_EN
    ,
    .err_cnt           (err_cnt)
`endif
  );

  typedef struct {
    logic [7:0] d;
    logic       s;
    logic       e;
  } beat_t;

  beat_t exp_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  bit    rdy_toggle = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ready_in driver: steady high, or toggling every cycle.
  initial begin
    ready_in = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_toggle) ready_in = ~ready_in;
      else            ready_in = 1'b1;
    end
  end

  // Output monitor / scoreboard.
  initial begin
    beat_t      e;
    bit         hold_chk = 1'b0;
    logic [7:0] hold_d   = '0;
    logic       hold_s   = 1'b0;
    logic       hold_e   = 1'b0;
    forever begin
      @(negedge clk);
      if (hold_chk) begin
        check_val("hold_valid", valid_out, 1);
        check_val("hold_data", data_out, hold_d);
        check_val("hold_sop", sop_out, hold_s);
        check_val("hold_eop", eop_out, hold_e);
      end
      hold_chk = valid_out && !ready_in;
      hold_d   = data_out;
      hold_s   = sop_out;
      hold_e   = eop_out;
      if (valid_out && ready_in) begin
        if (exp_q.size() == 0) begin
          check_val("spurious_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check_val("res_data", data_out, e.d);
          check_val("res_sop", sop_out, e.s);
          check_val("res_eop", eop_out, e.e);
          if (e.e) begin
            @(posedge clk);
            #1;
            check_val("ready_after_eop", ready_out, 1);
          end
        end
      end
    end
  end

  task automatic drive_beat(input logic [7:0] d, input logic s, input logic e);
    int guard = 0;
    @(negedge clk);
    data_in  = d;
    valid_in = 1'b1;
    sop_in   = s;
    eop_in   = e;
    while (!ready_out && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!ready_out) check_val("drive_timeout", ready_out, 1);
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    sop_in   = 1'b0;
    eop_in   = 1'b0;
  endtask

  task automatic push_result(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    beat_t       t;
    p = {32'd0, a} * {32'd0, b};
    for (int i = 0; i < 8; i++) begin
      t.d = p[i*8 +: 8];
      t.s = (i == 0);
      t.e = (i == 7);
      exp_q.push_back(t);
    end
  endtask

  task automatic send_operands(input logic [31:0] a, input logic [31:0] b, input bit chk_lat);
    logic [63:0] w;
    w = {b, a};
    push_result(a, b);
    for (int i = 0; i < 8; i++) drive_beat(w[i*8 +: 8], i == 0, i == 7);
    if (chk_lat) begin
      @(posedge clk);
      #1;
      check_val("lat_k1_valid", valid_out, 0);
      check_val("lat_k1_ready", ready_out, 0);
      @(posedge clk);
      #1;
      check_val("lat_k2_valid", valid_out, 1);
      check_val("lat_k2_sop", sop_out, 1);
    end
  endtask

  task automatic wait_drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    check_val("drain", exp_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int guard;
    _rst     = 1'b1;
    data_in  = '0;
    valid_in = 1'b0;
    sop_in   = 1'b0;
    eop_in   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_valid", valid_out, 0);
    check_val("rst_ready", ready_out, 0);
    _rst = 1'b0;
    #1;
    check_val("post_rst_ready", ready_out, 1);
    check_val("post_rst_data", data_out, 0);
    check_val("post_rst_sop", sop_out, 0);
    check_val("post_rst_eop", eop_out, 0);
`ifdef AVST_MUL_ERR_CNT_EN
    check_val("err_cnt_rst", err_cnt, 0);
`endif

    // Basic product, latency check.
    send_operands(32'd10234, 32'd566, 1'b1);
    wait_drain();

    // ready_in toggling.
    rdy_toggle = 1'b1;
    send_operands(32'd32, 32'd12, 1'b1);
    wait_drain();
    rdy_toggle = 1'b0;

    // Full-scale operands.
    send_operands(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait_drain();

    // Short packet: eop on beat 5.
    for (int i = 0; i < 6; i++) drive_beat(8'(8'h30 + i), i == 0, i == 5);
    #1;
    check_val("short_ready", ready_out, 1);
`ifdef AVST_MUL_ERR_CNT_EN
    check_val("err_cnt_short", err_cnt, 1);
`endif
    send_operands(32'd7, 32'd9, 1'b1);
    wait_drain();

    // Long packet: 10 beats, eop on beat 9.
    for (int i = 0; i < 10; i++) drive_beat(8'(8'h50 + i), i == 0, i == 9);
    repeat (4) @(negedge clk);
    check_val("long_no_valid", valid_out, 0);
    check_val("long_ready", ready_out, 1);
`ifdef AVST_MUL_ERR_CNT_EN
    check_val("err_cnt_long", err_cnt, 2);
`endif

    // Mid-packet sop restarts collection with the new bytes.
    for (int i = 0; i < 3; i++) drive_beat(8'hEE, i == 0, 1'b0);
    send_operands(32'h0001_2345, 32'h0000_0ABC, 1'b1);
    wait_drain();
`ifdef AVST_MUL_ERR_CNT_EN
    check_val("err_cnt_restart", err_cnt, 2);
`endif

    // Reset while result beat 3 is presented.
    send_operands(32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    guard = 0;
    while (exp_q.size() != 5 && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check_val("rst_mid_reach", exp_q.size(), 5);
    _rst = 1'b1;
    @(posedge clk);
    #1;
    check_val("rst_mid_valid", valid_out, 0);
    check_val("rst_mid_ready", ready_out, 0);
    check_val("rst_mid_data", data_out, 0);
    exp_q.delete();
    _rst = 1'b0;
    #1;
    check_val("rst_mid_ready_after", ready_out, 1);
`ifdef AVST_MUL_ERR_CNT_EN
    check_val("err_cnt_after_rst", err_cnt, 0);
`endif
    send_operands(32'd100000, 32'd300000, 1'b1);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/avalon_st_mul_responder.md
Name: avalon_st_mul_responder

Overview:
- Responder end of the byte-wide Avalon-ST operand/result link, paired with the existing initiator wrapper.
- Accepts one operand packet carrying A then B, computes the unsigned product A*B and returns it as one result packet.
- Sits on the initiator's output clock domain. It is a single-clock block; no CDC logic is inside it.

Parameters:
- SZ, 32, operand width in bits; must be a multiple of DSZ.
- DSZ, 8, symbol/beat width in bits.

Ports:
- clk  input  1  sole clock; all logic on rising edge.
- _rst  input  1  synchronous reset, active-high: _rst=1 on a rising edge resets the block.
- data_in  input  DSZ  operand beat.
- valid_in  input  1  operand beat valid.
- startofpacket_in  input  1  first operand beat.
- endofpacket_in  input  1  last operand beat.
- ready_out  output  1  responder can accept an operand beat.
- data_out  output  DSZ  result beat.
- valid_out  output  1  result beat valid.
- startofpacket_out  output  1  first result beat.
- endofpacket_out  output  1  last result beat.
- ready_in  input  1  initiator accepts the result beat.

Behaviour:
- Transfers: ready latency 0. A beat transfers on any edge where valid and ready are both 1.
- Operand packet: NIN = 2*SZ/DSZ beats (8 at defaults).
  - A occupies the first NIN/2 beats, least-significant byte first; B occupies the rest, also LSB first.
  - sop is set on beat 0 and eop on beat NIN-1.
- Result packet: NOUT = 2*SZ/DSZ beats (8), product least-significant byte first, sop on beat 0, eop on beat NOUT-1.
- Arithmetic: product = A*B, unsigned, full 2*SZ bits, never truncated.
- FSM states: IDLE, RECV, DROP, CALC, SEND.
  - IDLE: ready_out=1. A beat without sop is discarded. A sop beat stores byte 0, cnt=1, goes to RECV.
  - RECV: ready_out=1. Each beat stores byte cnt and increments cnt.
    - sop mid-packet: restart; the beat becomes byte 0, cnt=1.
    - eop with cnt==NIN-1: store byte, go to CALC.
    - eop early (short packet): discard the packet, go to IDLE, raise error event.
    - beat NIN-1 without eop (long packet): raise error event, go to DROP.
  - DROP: ready_out=1. Discard beats until eop accepted, then go to IDLE.
  - CALC: ready_out=0 for exactly one cycle. Product is registered into the output shift register; go to SEND.
  - SEND: ready_out=0. valid_out=1 with the current byte.
    - data/sop/eop hold stable while ready_in=0.
    - On each accepted beat, shift by DSZ.
    - After the eop beat is accepted, go to IDLE.
- Latency: last operand beat accepted at edge k; the first result beat is valid after edge k+2. ready_out is high again after the edge that accepts the last result beat.
- No overlap: operands are never accepted while a result is pending.
- Reset (any state, including mid-packet or mid-SEND):
  - Outputs: valid_out=0, sop/eop_out=0, data_out=0, ready_out=0 during reset, ready_out=1 on the first cycle after.
  - Internal: state=IDLE, cnt=0, registers cleared; the partial packet is lost.

Optional Feature:
- Macro AVST_MUL_ERR_CNT_EN.
- When defined, add port err_cnt (output, 8 bits): a saturating count of short and long packet error events. It is cleared by reset and holds at 255.
- When undefined, the port and counter are absent. Malformed packets are still dropped silently with identical timing.

Decomposition:
- Package avalon_st_pkg holds:
  - SZ and DSZ defaults, and localparams NIN, NOUT and the beat-counter width.
  - The state enum typedef (IDLE, RECV, DROP, CALC, SEND), shared with the initiator.
- One sub-module, avalon_st_tx_serializer: loads a 2*SZ word and emits NOUT beats with sop/eop and valid/ready hold.

Test Plan:
- A=10234, B=566, ready_in=1 → result beats BC 62 58 00 00 00 00 00 (0x5862BC); sop on beat 0, eop on beat 7; first valid 2 cycles after the operand eop.
- A=32, B=12, ready_in toggling 1/0 every cycle → beats 80 01 00 00 00 00 00 00 (0x180); each byte held stable while ready_in=0; no duplicated or skipped beats.
- A=B=0xFFFFFFFF → beats 01 00 00 00 FE FF FF FF.
- Short packet: eop on beat 5 → no result packet; ready_out stays 1; a following valid packet gives the correct product; err_cnt=1 when AVST_MUL_ERR_CNT_EN is defined.
- 10-beat packet without eop until beat 9 → beats dropped through eop, no result, err_cnt increments; a mid-packet sop instead restarts and the product uses the new bytes.
- _rst=1 during SEND beat 3 → next cycle valid_out=0 and ready_out=0; after release ready_out=1 and a new packet is processed normally.
